alu_issue_ctrl: RTL



---
 rtl/alu_issue_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequencing front-end for the 8-bit ALU.
// Accepts an instruction, reads two operands from the internal register file,
// presents them to the ALU, captures the result and writes it back.
// Optional build macro: DIV0_TRAP_EN (divide-by-zero traps instead of writing back).
module alu_issue_ctrl #(
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [4+3*ADDR_W-1:0] instr,
    input  logic                  host_wr_en,
    input  logic [ADDR_W-1:0]     host_wr_addr,
    input  logic [7:0]            host_wr_data,
    input  logic [ADDR_W-1:0]     dbg_rd_addr,
    output logic [7:0]            dbg_rd_data,
    output logic [7:0]            alu_operand1,
    output logic [7:0]            alu_operand2,
    output logic [3:0]            alu_opcode,
    input  logic [15:0]           alu_result,
    input  logic                  alu_flagC,
    output logic                  done,
    output logic [15:0]           result_out,
    output logic                  flag_c,
    output logic                  flag_z,
    output logic                  div0_err
);

    localparam int IW   = 4 + 3 * ADDR_W;
    localparam int NREG = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;

    logic [1:0]        state_q, state_d;
    logic [3:0]        opcode_q;
    logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
    logic [ADDR_W-1:0] rdPlusOne;
    logic [7:0]        regFile_q [NREG];
    logic [7:0]        regFile_d [NREG];
    logic [7:0]        operand1_q, operand2_q;
    logic [3:0]        aluOpcode_q;
    logic [15:0]       wbResult_q;
    logic              wbCarry_q;
    logic              trap_q;
    logic              divTrap;
    logic              done_q;
    logic [15:0]       resultOut_q;
    logic              flagC_q, flagZ_q;
    logic              carryOp;

    assign instr_ready  = (state_q == S_IDLE);
    assign dbg_rd_data  = regFile_q[dbg_rd_addr];
    assign alu_operand1 = operand1_q;
    assign alu_operand2 = operand2_q;
    assign alu_opcode   = aluOpcode_q;
    assign done         = done_q;
    assign result_out   = resultOut_q;
    assign flag_c       = flagC_q;
    assign flag_z       = flagZ_q;
    assign rdPlusOne    = rd_q + ADDR_W'(1);
    assign carryOp      = (opcode_q == OP_ADD) || (opcode_q == OP_SUB);

`ifdef DIV0_TRAP_EN
    logic div0Err_q;

    assign divTrap  = (opcode_q == OP_DIV) && (operand2_q == 8'h00);
    assign div0_err = div0Err_q;

    // Pulse the divide-by-zero error alongside done for a trapped instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            div0Err_q <= 1'b0;
        end else begin
            div0Err_q <= (state_q == S_WB) && trap_q;
        end
    end
`else
    assign divTrap  = 1'b0;
    assign div0_err = 1'b0;
`endif

    // Advance through accept, operand read, execute and writeback.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Register file next value: host load first, writeback overrides it on a collision.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regFile_d[i] = regFile_q[i];
        end
        if (host_wr_en) begin
            regFile_d[host_wr_addr] = host_wr_data;
        end
        if ((state_q == S_WB) && !trap_q) begin
            regFile_d[rd_q] = wbResult_q[7:0];
            if (opcode_q == OP_MUL) begin
                regFile_d[rdPlusOne] = wbResult_q[15:8];
            end
        end
    end

    // Register file storage; reset clears it and drops any coincident host write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regFile_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regFile_q[i] <= regFile_d[i];
            end
        end
    end

    // Pipeline datapath: latch the instruction, drive the ALU, capture and retire the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            opcode_q    <= 4'h0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            operand1_q  <= 8'h00;
            operand2_q  <= 8'h00;
            aluOpcode_q <= 4'h0;
            wbResult_q  <= 16'h0000;
            wbCarry_q   <= 1'b0;
            trap_q      <= 1'b0;
            done_q      <= 1'b0;
            resultOut_q <= 16'h0000;
            flagC_q     <= 1'b0;
            flagZ_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        opcode_q <= instr[IW-1 -: 4];
                        rd_q     <= instr[3*ADDR_W-1 -: ADDR_W];
                        rs1_q    <= instr[2*ADDR_W-1 -: ADDR_W];
                        rs2_q    <= instr[ADDR_W-1:0];
                    end
                end
                S_READ: begin
                    operand1_q  <= regFile_q[rs1_q];
                    operand2_q  <= regFile_q[rs2_q];
                    aluOpcode_q <= opcode_q;
                end
                S_EXEC: begin
                    wbResult_q <= alu_result;
                    wbCarry_q  <= alu_flagC;
                    trap_q     <= divTrap;
                end
                S_WB: begin
                    done_q <= 1'b1;
                    if (!trap_q) begin
                        resultOut_q <= wbResult_q;
                        flagZ_q     <= (wbResult_q == 16'h0000);
                        if (carryOp) begin
                            flagC_q <= wbCarry_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
